// File: rtl/aes_job_arbiter.sv
// Round-robin job scheduler that shares one aes_core between two requesters, sequences the
// core's load pulse, guards the run phase with a timeout and returns results on a valid/ready port.
module aes_job_arbiter #(
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         int_osc,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [127:0] key0,
  input  logic [127:0] key1,
  input  logic [127:0] pt0,
  input  logic [127:0] pt1,
  output logic [1:0]   acc,
  output logic         core_load,
  output logic [127:0] core_key,
  output logic [127:0] core_plaintext,
  input  logic         core_done,
  input  logic [127:0] core_cyphertext,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [127:0] rsp_data,
  output logic         busy
);

  localparam int unsigned LdW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  logic [1:0]     state_q, state_d;
  logic           last_q, last_d;
  logic [1:0]     acc_q, acc_d;
  logic [127:0]   core_key_q, core_key_d;
  logic [127:0]   core_pt_q, core_pt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic [LdW-1:0] ld_cnt_q, ld_cnt_d;
  logic [7:0]     tmo_cnt_q, tmo_cnt_d;
  logic           grant;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    acc_d       = 2'b00;
    core_key_d  = core_key_q;
    core_pt_d   = core_pt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    ld_cnt_d    = ld_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    grant       = 1'b0;

    case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // On a tie the channel that was not served last wins.
          grant      = (req == 2'b11) ? ~last_q : req[1];
          core_key_d = grant ? key1 : key0;
          core_pt_d  = grant ? pt1 : pt0;
          rsp_id_d   = grant;
          acc_d      = grant ? 2'b10 : 2'b01;
          ld_cnt_d   = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (ld_cnt_q == LdW'(LOAD_CYCLES - 1)) begin
          tmo_cnt_d = 8'd0;
          state_d   = StRun;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      StRun: begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (core_done) begin
          rsp_data_d  = core_cyphertext;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = rsp_id_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      acc_q       <= 2'b00;
      core_key_q  <= '0;
      core_pt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      ld_cnt_q    <= '0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      core_key_q  <= core_key_d;
      core_pt_q   <= core_pt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      ld_cnt_q    <= ld_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign acc            = acc_q;
  assign core_load      = (state_q == StLoad);
  assign core_key       = core_key_q;
  assign core_plaintext = core_pt_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_data       = rsp_data_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter: behavioural aes_core stand-in with programmable latency and a
// job-level reference model (round-robin pointer, expected response cycle and payload).
module tb_aes_job_arbiter;

  localparam int unsigned LC  = 2;
  localparam int unsigned TMO = 48;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         int_osc = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [127:0] key0, key1, pt0, pt1;
  logic [1:0]   acc;
  logic         core_load;
  logic [127:0] core_key, core_plaintext;
  logic         core_done;
  logic [127:0] core_cyphertext;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [127:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit last_m;
  int core_lat;
  int core_cnt;
  logic [127:0] core_k, core_p;

  always #5 int_osc = ~int_osc;

  aes_job_arbiter #(
    .LOAD_CYCLES   (LC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .int_osc        (int_osc),
    .reset          (reset),
    .req            (req),
    .key0           (key0),
    .key1           (key1),
    .pt0            (pt0),
    .pt1            (pt1),
    .acc            (acc),
    .core_load      (core_load),
    .core_key       (core_key),
    .core_plaintext (core_plaintext),
    .core_done      (core_done),
    .core_cyphertext(core_cyphertext),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_err        (rsp_err),
    .rsp_data       (rsp_data),
    .busy           (busy)
  );

  // Stand-in cipher: the FIPS-197 pair maps to its known ciphertext, anything else to a mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {k[63:0], k[127:64]} ^ p ^ 128'hc3a5_1e0f_7788_2b4d_9e61_0af3_55cc_d201;
  endfunction

  // Core model: load clears sticky done; done rises core_lat cycles after load ends (0 = never).
  always @(posedge int_osc) begin
    if (reset) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_k    <= '0;
      core_p    <= '0;
    end else if (core_load) begin
      core_done <= 1'b0;
      core_cnt  <= core_lat;
      core_k    <= core_key;
      core_p    <= core_plaintext;
    end else if (core_cnt == 1) begin
      core_done <= 1'b1;
      core_cnt  <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign core_cyphertext = core_fn(core_k, core_p);

  task automatic tick;
    @(posedge int_osc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_load"}, core_load, 0);
    chk({tag, "_key"}, core_key, 0);
    chk({tag, "_pt"}, core_plaintext, 0);
    chk({tag, "_valid"}, rsp_valid, 0);
    chk({tag, "_id"}, rsp_id, 0);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_data"}, rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Runs one job whose grant decision is the current cycle (DUT idle). hold keeps req asserted
  // after the accept; no_ack leaves the DUT sitting in the response phase.
  task automatic do_job(input logic [1:0] reqv, input int lat, input int stall,
                        input bit hold, input bit no_ack);
    int g, off, n;
    bit err;
    logic [127:0] k, p, exp_d;
    g = (reqv == 2'b11) ? (last_m ? 0 : 1) : (reqv[1] ? 1 : 0);
    k = g ? key1 : key0;
    p = g ? pt1 : pt0;
    err   = !(lat >= 1 && lat < int'(TMO));
    off   = err ? int'(TMO) : lat + 1;
    exp_d = err ? 128'h0 : core_fn(k, p);
    core_lat  = lat;
    rsp_ready = 1'b0;
    req = reqv;
    chk("idle_before_grant", busy, 0);
    tick;
    chk("acc_onehot", acc, (g == 1) ? 2'b10 : 2'b01);
    chk("load_first", core_load, 1);
    chk("busy_job", busy, 1);
    chk("core_key", core_key, k);
    chk("core_pt", core_plaintext, p);
    if (!hold) req = 2'b00;
    for (int i = 1; i < int'(LC); i++) begin
      tick;
      chk("acc_single", acc, 0);
      chk("load_hold", core_load, 1);
    end
    tick;
    chk("load_fall", core_load, 0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < int'(TMO) + 10) begin
      tick;
      chk("acc_quiet_run", acc, 0);
      n++;
    end
    chk("rsp_latency", n, off);
    chk("rsp_id", rsp_id, g);
    chk("rsp_err", rsp_err, err);
    chk("rsp_data", rsp_data, exp_d);
    for (int i = 0; i < stall; i++) begin
      tick;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, exp_d);
      chk("bp_acc", acc, 0);
      chk("bp_key", core_key, k);
    end
    if (no_ack) return;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("ack_valid_drop", rsp_valid, 0);
    chk("ack_idle", busy, 0);
    last_m = g[0];
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; rsp_ready = 1'b0; core_lat = 0;
    key0 = '0; key1 = '0; pt0 = '0; pt1 = '0;
    last_m = 1'b1;
    tick; tick; tick;
    chk_reset_outs("rst");
    reset = 1'b0;
    tick;
    chk_reset_outs("rst_idle");

    // FIPS-197 single job on channel 0.
    key0 = FIPS_KEY; pt0 = FIPS_PT;
    do_job(2'b01, 40, 0, 1'b0, 1'b0);

    // Both requesters held high: grants alternate.
    key1 = rand128(); pt1 = rand128();
    for (int j = 0; j < 4; j++) do_job(2'b11, 5 + j, 0, (j < 3), 1'b0);

    // Backpressure with both requesting, then immediate regrant after the handshake.
    do_job(2'b11, 3, 20, 1'b1, 1'b0);
    do_job(2'b11, 4, 0, 1'b0, 1'b0);

    // Timeouts (never done, done one cycle late), recovery, and done on the limit cycle.
    do_job(2'b01, 0, 0, 1'b0, 1'b0);
    do_job(2'b10, 6, 0, 1'b0, 1'b0);
    do_job(2'b01, TMO, 1, 1'b0, 1'b0);
    do_job(2'b10, TMO - 1, 0, 1'b0, 1'b0);

    // Reset during LOAD.
    core_lat = 5;
    req = 2'b10;
    tick;
    chk("pre_rst_acc", acc, 2'b10);
    tick;
    chk("pre_rst_load", core_load, 1);
    reset = 1'b1; req = 2'b00;
    tick;
    chk_reset_outs("rst_load");
    reset = 1'b0; last_m = 1'b1;
    do_job(2'b11, 7, 0, 1'b0, 1'b0);

    // Reset during RESP.
    do_job(2'b10, 3, 2, 1'b0, 1'b1);
    reset = 1'b1;
    tick;
    chk_reset_outs("rst_resp");
    reset = 1'b0; last_m = 1'b1;
    do_job(2'b11, 2, 0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 14; j++) begin
      logic [1:0] r;
      int lat;
      key0 = rand128(); key1 = rand128(); pt0 = rand128(); pt1 = rand128();
      r   = 2'($urandom_range(1, 3));
      lat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TMO + 2))
                                        : int'($urandom_range(1, 12));
      do_job(r, lat, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
